// File: rtl/square_scheduler_pkg.sv
// Shared types and default widths for the square scheduler.
// Descriptor layout and FSM state encoding live here.
package square_pkg;

  localparam int SQ_N_SQUARES = 4;
  localparam int SQ_COORD_W   = 13;
  localparam int SQ_SIZE_W    = 11;
  localparam int SQ_COLOR_W   = 20;

  localparam logic [SQ_COLOR_W-1:0] SQ_BG_COLOR = '0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    OUT  = 2'd2
  } sched_state_e;

  typedef struct packed {
    logic                  en;
    logic [SQ_COORD_W-1:0] x;
    logic [SQ_COORD_W-1:0] y;
    logic [SQ_SIZE_W-1:0]  size;
    logic [SQ_COLOR_W-1:0] color;
  } square_desc_t;

  // Right/bottom edge computed one bit wider so it never wraps.
  function automatic logic [SQ_COORD_W:0] edge_end(
    input logic [SQ_COORD_W-1:0] base,
    input logic [SQ_SIZE_W-1:0]  size
  );
    logic [SQ_COORD_W:0] w_b;
    logic [SQ_COORD_W:0] w_s;
    w_b = {1'b0, base};
    w_s = {{(SQ_COORD_W + 1 - SQ_SIZE_W){1'b0}}, size};
    return w_b + w_s;
  endfunction

endpackage

// File: rtl/square_scheduler_hit.sv
// Combinational point-in-square test for one descriptor.
// Left/top edges inclusive, right/bottom exclusive.
module square_hit
  import square_pkg::*;
(
  input  square_desc_t          i_desc,
  input  logic [SQ_COORD_W-1:0] i_px,
  input  logic [SQ_COORD_W-1:0] i_py,
  output logic                  o_hit
);

  logic [SQ_COORD_W:0] w_x_end;
  logic [SQ_COORD_W:0] w_y_end;
  logic                w_in_x;
  logic                w_in_y;

  assign w_x_end = edge_end(i_desc.x, i_desc.size);
  assign w_y_end = edge_end(i_desc.y, i_desc.size);

  assign w_in_x = (i_px >= i_desc.x) &&
                  ({1'b0, i_px} < w_x_end);
  assign w_in_y = (i_py >= i_desc.y) &&
                  ({1'b0, i_py} < w_y_end);

  assign o_hit = i_desc.en && w_in_x && w_in_y;

endmodule

// File: rtl/square_scheduler.sv
// Time-shared point-in-square scheduler: one query scans the
// descriptor table in priority order through a single hit unit.
module square_scheduler
  import square_pkg::*;
#(
  parameter int N_SQUARES = SQ_N_SQUARES,
  parameter logic [SQ_COLOR_W-1:0] BG_COLOR = SQ_BG_COLOR,
  localparam int IDX_W = $clog2(N_SQUARES)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cfg_we,
  input  logic [IDX_W-1:0]      cfg_idx,
  input  logic                  cfg_en,
  input  logic [SQ_COORD_W-1:0] cfg_x,
  input  logic [SQ_COORD_W-1:0] cfg_y,
  input  logic [SQ_SIZE_W-1:0]  cfg_size,
  input  logic [SQ_COLOR_W-1:0] cfg_color,
  input  logic                  px_valid,
  output logic                  px_ready,
  input  logic [SQ_COORD_W-1:0] px_x,
  input  logic [SQ_COORD_W-1:0] px_y,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [SQ_COLOR_W-1:0] out_color,
  output logic                  out_hit,
  output logic [IDX_W-1:0]      out_idx
);

  square_desc_t          r_desc [N_SQUARES];
  sched_state_e          r_state;
  sched_state_e          w_next;
  logic [SQ_COORD_W-1:0] r_px;
  logic [SQ_COORD_W-1:0] r_py;
  logic [IDX_W-1:0]      r_idx;
  logic [SQ_COLOR_W-1:0] r_out_color;
  logic                  r_out_hit;
  logic [IDX_W-1:0]      r_out_idx;
  logic                  r_out_valid;

  square_desc_t          w_desc;
  logic                  w_hit;
  logic                  w_last;
  logic                  w_cfg_ok;

  assign w_cfg_ok = ({1'b0, cfg_idx} <
                     (IDX_W + 1)'(N_SQUARES));
  assign w_last   = (r_idx == IDX_W'(N_SQUARES - 1));
  assign w_desc   = r_desc[r_idx];

  square_hit u_hit (
    .i_desc (w_desc),
    .i_px   (r_px),
    .i_py   (r_py),
    .o_hit  (w_hit)
  );

  // Live table: a slot written mid-scan is seen if not yet tested.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N_SQUARES; i++) begin
        r_desc[i] <= '0;
      end
    end else if (cfg_we && w_cfg_ok) begin
      r_desc[cfg_idx] <= '{
        en:    cfg_en,
        x:     cfg_x,
        y:     cfg_y,
        size:  cfg_size,
        color: cfg_color
      };
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE: begin
        if (px_valid) begin
          w_next = SCAN;
        end
      end
      SCAN: begin
        if (w_hit || w_last) begin
          w_next = OUT;
        end
      end
      OUT: begin
        if (r_out_valid && out_ready) begin
          w_next = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_px        <= '0;
      r_py        <= '0;
      r_idx       <= '0;
      r_out_color <= BG_COLOR;
      r_out_hit   <= 1'b0;
      r_out_idx   <= '0;
      r_out_valid <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          r_out_valid <= 1'b0;
          if (px_valid) begin
            r_px  <= px_x;
            r_py  <= px_y;
            r_idx <= '0;
          end
        end
        SCAN: begin
          if (w_hit) begin
            r_out_color <= w_desc.color;
            r_out_hit   <= 1'b1;
            r_out_idx   <= r_idx;
          end else if (w_last) begin
            r_out_color <= BG_COLOR;
            r_out_hit   <= 1'b0;
            r_out_idx   <= '0;
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
        OUT: begin
          // First OUT cycle stages the result; it then holds until taken.
          r_out_valid <= !r_out_valid || !out_ready;
        end
        default: r_out_valid <= 1'b0;
      endcase
    end
  end

  assign px_ready  = (r_state == IDLE);
  assign out_valid = r_out_valid;
  assign out_color = r_out_color;
  assign out_hit   = r_out_hit;
  assign out_idx   = r_out_idx;

endmodule

// File: tb/tb_square_scheduler.sv
// Self-checking bench for square_scheduler: directed table,
// multi-cycle corner sequences and randomized model comparison.
module tb_square_scheduler;

  localparam int N  = 4;
  localparam int IW = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          cfg_we;
  logic [IW-1:0] cfg_idx;
  logic          cfg_en;
  logic [12:0]   cfg_x;
  logic [12:0]   cfg_y;
  logic [10:0]   cfg_size;
  logic [19:0]   cfg_color;
  logic          px_valid;
  logic          px_ready;
  logic [12:0]   px_x;
  logic [12:0]   px_y;
  logic          out_valid;
  logic          out_ready;
  logic [19:0]   out_color;
  logic          out_hit;
  logic [IW-1:0] out_idx;

  square_scheduler dut (
    .clk       (clk),
    .rst       (rst),
    .cfg_we    (cfg_we),
    .cfg_idx   (cfg_idx),
    .cfg_en    (cfg_en),
    .cfg_x     (cfg_x),
    .cfg_y     (cfg_y),
    .cfg_size  (cfg_size),
    .cfg_color (cfg_color),
    .px_valid  (px_valid),
    .px_ready  (px_ready),
    .px_x      (px_x),
    .px_y      (px_y),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_color (out_color),
    .out_hit   (out_hit),
    .out_idx   (out_idx)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  int m_en [N];
  int m_x  [N];
  int m_y  [N];
  int m_sz [N];
  int m_c  [N];

  typedef struct {
    int x;
    int y;
    int hit;
    int idx;
    int col;
    int lat;
  } vec_t;

  vec_t vt [9];

  task automatic chk(input string name,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
    end
  endtask

  // Reference: first enabled square (lowest index) containing the point.
  function automatic void model(input int px, input int py,
                                output int hit, output int idx,
                                output int col, output int lat);
    hit = 0;
    idx = 0;
    col = 0;
    lat = N + 1;
    for (int i = 0; i < N; i++) begin
      if (m_en[i] != 0 &&
          px >= m_x[i] && px < m_x[i] + m_sz[i] &&
          py >= m_y[i] && py < m_y[i] + m_sz[i]) begin
        hit = 1;
        idx = i;
        col = m_c[i];
        lat = i + 2;
        break;
      end
    end
  endfunction

  task automatic drive_cfg(input int i, input int en, input int x,
                           input int y, input int sz, input int c);
    cfg_we    = 1'b1;
    cfg_idx   = IW'(i);
    cfg_en    = (en != 0);
    cfg_x     = 13'(x);
    cfg_y     = 13'(y);
    cfg_size  = 11'(sz);
    cfg_color = 20'(c);
    m_en[i] = en;
    m_x[i]  = x;
    m_y[i]  = y;
    m_sz[i] = sz;
    m_c[i]  = c;
  endtask

  task automatic write_slot(input int i, input int en, input int x,
                            input int y, input int sz, input int c);
    @(negedge clk);
    drive_cfg(i, en, x, y, sz, c);
    @(posedge clk);
    #1 cfg_we = 1'b0;
  endtask

  task automatic start_query(input int x, input int y);
    @(negedge clk);
    px_x     = 13'(x);
    px_y     = 13'(y);
    px_valid = 1'b1;
    chk("px_ready_idle", px_ready, 1);
    @(posedge clk);
    #1 px_valid = 1'b0;
  endtask

  task automatic wait_result(input int lat0, output int lat);
    bit got;
    got = 0;
    lat = lat0;
    for (int k = 0; k < 40 && !got; k++) begin
      @(posedge clk);
      #1;
      lat++;
      if (out_valid) got = 1;
    end
    if (!got) chk("result_timeout", 0, 1);
  endtask

  task automatic consume(input int hold);
    repeat (hold) begin
      @(negedge clk);
      chk("hold_valid", out_valid, 1);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    chk("valid_drop", out_valid, 0);
  endtask

  task automatic check_res(input string tag, input int lat,
                           input int eh, input int ei,
                           input int ec, input int el);
    chk({tag, "_lat"},   lat,       el);
    chk({tag, "_hit"},   out_hit,   eh);
    chk({tag, "_idx"},   out_idx,   ei);
    chk({tag, "_color"}, out_color, ec);
  endtask

  task automatic query_check(input string tag, input int x,
                             input int y, input int eh,
                             input int ei, input int ec,
                             input int el, input int hold);
    int lat;
    start_query(x, y);
    wait_result(0, lat);
    check_res(tag, lat, eh, ei, ec, el);
    consume(hold);
  endtask

  task automatic model_query(input string tag, input int x,
                             input int y, input int hold);
    int eh, ei, ec, el;
    model(x, y, eh, ei, ec, el);
    query_check(tag, x, y, eh, ei, ec, el, hold);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int lat;
    rst       = 1'b1;
    cfg_we    = 1'b0;
    cfg_idx   = '0;
    cfg_en    = 1'b0;
    cfg_x     = '0;
    cfg_y     = '0;
    cfg_size  = '0;
    cfg_color = '0;
    px_valid  = 1'b0;
    px_x      = '0;
    px_y      = '0;
    out_ready = 1'b0;
    for (int i = 0; i < N; i++) begin
      m_en[i] = 0;
      m_x[i]  = 0;
      m_y[i]  = 0;
      m_sz[i] = 0;
      m_c[i]  = 0;
    end

    repeat (3) @(posedge clk);
    #1;
    chk("rst_px_ready",  px_ready,  1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_hit",   out_hit,   0);
    chk("rst_out_idx",   out_idx,   0);
    chk("rst_out_color", out_color, 0);
    @(negedge clk);
    rst = 1'b0;

    query_check("empty", 5, 5, 0, 0, 0, 5, 0);

    write_slot(0, 1, 40,   40,   20,   1);
    write_slot(1, 1, 8190, 8190, 2047, 'h11111);
    write_slot(2, 1, 100,  100,  10,   'hABCDE);
    write_slot(3, 1, 45,   45,   20,   3);

    vt[0] = '{5,    5,    0, 0, 0,        5};
    vt[1] = '{100,  100,  1, 2, 'hABCDE,  4};
    vt[2] = '{109,  109,  1, 2, 'hABCDE,  4};
    vt[3] = '{110,  105,  0, 0, 0,        5};
    vt[4] = '{50,   50,   1, 0, 1,        2};
    vt[5] = '{62,   62,   1, 3, 3,        5};
    vt[6] = '{8191, 8191, 1, 1, 'h11111,  3};
    vt[7] = '{8190, 8190, 1, 1, 'h11111,  3};
    vt[8] = '{8189, 8191, 0, 0, 0,        5};
    for (int v = 0; v < 9; v++) begin
      query_check($sformatf("vec%0d", v), vt[v].x, vt[v].y,
                  vt[v].hit, vt[v].idx, vt[v].col, vt[v].lat, v % 3);
    end

    write_slot(1, 1, 8190, 8190, 0, 'h11111);
    query_check("size0", 8191, 8191, 0, 0, 0, 5, 0);

    // Result must hold steady while downstream stalls.
    start_query(100, 100);
    wait_result(0, lat);
    check_res("stall", lat, 1, 2, 'hABCDE, 4);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      px_valid = 1'b1;
      chk("stall_valid", out_valid, 1);
      chk("stall_color", out_color, 'hABCDE);
      chk("stall_hit",   out_hit,   1);
      chk("stall_idx",   out_idx,   2);
      chk("stall_ready", px_ready,  0);
    end
    px_valid = 1'b0;
    consume(0);

    // Reset in the middle of a scan.
    start_query(5, 5);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_px_ready",  px_ready,  1);
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_out_hit",   out_hit,   0);
    chk("midrst_out_color", out_color, 0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < N; i++) m_en[i] = 0;
    query_check("post_rst_a", 100, 100, 0, 0, 0, 5, 0);
    query_check("post_rst_b", 50,  50,  0, 0, 0, 5, 0);

    // Table writes during a scan.
    start_query(200, 200);
    @(negedge clk);
    drive_cfg(3, 1, 200, 200, 5, 'h33333);
    @(negedge clk);
    drive_cfg(0, 1, 198, 198, 5, 'h00AAA);
    @(negedge clk);
    cfg_we = 1'b0;
    wait_result(2, lat);
    check_res("live_wr", lat, 1, 3, 'h33333, 5);
    consume(0);
    query_check("live_wr_next", 200, 200, 1, 0, 'h00AAA, 2, 0);

    for (int it = 0; it < 40; it++) begin
      int qx, qy;
      if (it % 8 == 0) begin
        for (int s = 0; s < N; s++) begin
          int x, y, sz;
          if ($urandom_range(0, 3) == 0) begin
            x  = 8100 + int'($urandom_range(0, 91));
            y  = 8100 + int'($urandom_range(0, 91));
            sz = int'($urandom_range(0, 2047));
          end else begin
            x  = int'($urandom_range(0, 60));
            y  = int'($urandom_range(0, 60));
            sz = int'($urandom_range(0, 25));
          end
          write_slot(s, ($urandom_range(0, 3) != 0) ? 1 : 0,
                     x, y, sz, int'($urandom & 32'hFFFFF));
        end
      end
      if ($urandom_range(0, 3) == 0) begin
        qx = 8100 + int'($urandom_range(0, 91));
        qy = 8100 + int'($urandom_range(0, 91));
      end else begin
        qx = int'($urandom_range(0, 80));
        qy = int'($urandom_range(0, 80));
      end
      model_query($sformatf("rnd%0d", it), qx, qy,
                  int'($urandom_range(0, 2)));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
